// File: rtl/sop_scanner_pkg.sv
// Shared types and constants for the sequential SoP truth-table scanner.
// No ports: provides the scanner FSM state type, table geometry and the
// golden minterm mask of (a'.c.d') + (b.c) + (a.b.d').
package sop_scanner_pkg;

    localparam int unsigned N_IN    = 4;
    localparam int unsigned TABLE_W = 2 ** N_IN;
    localparam int unsigned ERR_W   = N_IN + 1;

    localparam logic [TABLE_W-1:0] SOP_C_MASK = 16'hD0C4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/sop_scanner_if.sv
// Scanner control/result bundle plus the stimulus/capture pair toward the
// function under test.
//   start, expected         : scan request and expected minterm mask
//   dut_in, dut_s           : vector driven to the function, its output
//   busy, done              : scan in progress, one-cycle completion pulse
//   tbl, match, err_count,
//   first_err, first_err_valid : captured table and comparison summary
// master = requester/function side, slave = scanner.
interface sop_scanner_if;
    import sop_scanner_pkg::*;

    logic               start;
    logic [TABLE_W-1:0] expected;
    logic [N_IN-1:0]    dut_in;
    logic               dut_s;
    logic               busy;
    logic               done;
    logic [TABLE_W-1:0] tbl;
    logic               match;
    logic [ERR_W-1:0]   err_count;
    logic [N_IN-1:0]    first_err;
    logic               first_err_valid;

    modport master (
        output start, expected, dut_s,
        input  dut_in, busy, done, tbl, match, err_count, first_err, first_err_valid
    );

    modport slave (
        input  start, expected, dut_s,
        output dut_in, busy, done, tbl, match, err_count, first_err, first_err_valid
    );

endinterface

// File: rtl/scan_settle_timer.sv
// Loadable down-counter timing how long each vector is held before sampling.
//   clk, rst  : clock, async active-high reset
//   load      : reload with SETTLE-1 (start of a vector)
//   en        : count down while holding a vector
//   expire_c  : counter reached zero (last hold cycle)
module scan_settle_timer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Count SETTLE-1 down to 0; hold at zero until reloaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(SETTLE - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expire_c = (cnt_q == '0);

endmodule

// File: rtl/sop_scanner.sv
// Sequential truth-table scanner: walks every input index in ascending
// order, holds each for SETTLE cycles, samples the function output and
// compares the assembled table against a latched expected mask.
//   clk, rst : clock, async active-high reset
//   bus      : sop_scanner_if.slave (request, stimulus/capture, results)
module sop_scanner
    import sop_scanner_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    sop_scanner_if.slave  bus
);

    state_t             state_q, state_d;
    logic [N_IN-1:0]    idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               match_q, match_d;
    logic [TABLE_W-1:0] tbl_q, tbl_d;
    logic [TABLE_W-1:0] exp_q, exp_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [N_IN-1:0]    first_q, first_d;
    logic               fev_q, fev_d;

    logic load_c;
    logic run_c;
    logic expire_c;
    logic mism_c;

    assign run_c = (state_q == APPLY);

    scan_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .en       (run_c),
        .expire_c (expire_c)
    );

    // Next-state and next-register values.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        match_d = match_q;
        tbl_d   = tbl_q;
        exp_d   = exp_q;
        err_d   = err_q;
        first_d = first_q;
        fev_d   = fev_q;
        load_c  = 1'b0;
        mism_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = APPLY;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    match_d = 1'b0;
                    tbl_d   = '0;
                    exp_d   = bus.expected;
                    err_d   = '0;
                    first_d = '0;
                    fev_d   = 1'b0;
                    load_c  = 1'b1;
                end
            end
            APPLY: begin
                if (expire_c) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // Case inequality so an X/Z output is reported as a mismatch.
                mism_c       = (bus.dut_s !== exp_q[idx_q]);
                tbl_d[idx_q] = bus.dut_s;
                err_d        = err_q + ERR_W'(mism_c);
                if (mism_c && !fev_q) begin
                    first_d = idx_q;
                    fev_d   = 1'b1;
                end
                if (idx_q == N_IN'(TABLE_W - 1)) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    match_d = (err_d == '0);
                end else begin
                    state_d = APPLY;
                    idx_d   = idx_q + N_IN'(1);
                    load_c  = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            tbl_q   <= '0;
            exp_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            fev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
            tbl_q   <= tbl_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            first_q <= first_d;
            fev_q   <= fev_d;
        end
    end

    // The index register doubles as the applied input vector.
    assign bus.dut_in          = idx_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.tbl             = tbl_q;
    assign bus.match           = match_q;
    assign bus.err_count       = err_q;
    assign bus.first_err       = first_q;
    assign bus.first_err_valid = fev_q;

endmodule

// File: tb/tb_sop_scanner.sv
// Scoreboard bench for sop_scanner: two instances (SETTLE=1 and SETTLE=3),
// stimulus pushes expected results, negedge monitors pop on done.
module tb_sop_scanner;
    import sop_scanner_pkg::*;

    typedef struct {
        logic [15:0] tbl;
        logic        match;
        logic [4:0]  err;
        logic [3:0]  first;
        logic        fev;
        int          done_at;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [15:0] func1;
    logic [15:0] sop_mask;

    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sop_scanner_if if1();
    sop_scanner_if if3();

    // Function under test: a truth-table lookup of the applied vector.
    assign if1.dut_s = func1[if1.dut_in];
    assign if3.dut_s = sop_mask[if3.dut_in];

    sop_scanner #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    sop_scanner #(.SETTLE(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    // (a'.c.d') + (b.c) + (a.b.d') evaluated per index.
    function automatic logic [15:0] sop_truth();
        logic [15:0] t;
        logic [3:0]  v;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            t[i] = (!v[3] && v[1] && !v[0]) || (v[2] && v[1]) || (v[3] && v[2] && !v[0]);
        end
        return t;
    endfunction

    function automatic exp_t model(input logic [15:0] f, input logic [15:0] e, input int done_at);
        exp_t        m;
        logic [15:0] diff;
        diff      = f ^ e;
        m.tbl     = f;
        m.err     = '0;
        m.first   = '0;
        m.fev     = 1'b0;
        m.done_at = done_at;
        for (int i = 0; i < 16; i++) begin
            if (diff[i]) begin
                m.err = m.err + 5'd1;
                if (!m.fev) begin
                    m.first = 4'(i);
                    m.fev   = 1'b1;
                end
            end
        end
        m.match = (diff == 16'h0);
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_reset1();
        chk("rst_dut_in", 32'(if1.dut_in), 32'(0));
        chk("rst_busy", 32'(if1.busy), 32'(0));
        chk("rst_done", 32'(if1.done), 32'(0));
        chk("rst_table", 32'(if1.tbl), 32'(0));
        chk("rst_match", 32'(if1.match), 32'(0));
        chk("rst_err_count", 32'(if1.err_count), 32'(0));
        chk("rst_first_err", 32'(if1.first_err), 32'(0));
        chk("rst_first_err_valid", 32'(if1.first_err_valid), 32'(0));
    endtask

    // Monitor for the SETTLE=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && if1.done === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done1 actual=done required=no_done");
            end else begin
                e = q1.pop_front();
                chk("table1", 32'(if1.tbl), 32'(e.tbl));
                chk("match1", 32'(if1.match), 32'(e.match));
                chk("err_count1", 32'(if1.err_count), 32'(e.err));
                chk("first_err1", 32'(if1.first_err), 32'(e.first));
                chk("first_err_valid1", 32'(if1.first_err_valid), 32'(e.fev));
                chk("done_cycle1", 32'(cyc), 32'(e.done_at));
                chk("busy_at_done1", 32'(if1.busy), 32'(0));
            end
        end
    end

    // Monitor for the SETTLE=3 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && if3.done === 1'b1) begin
            if (q3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done3 actual=done required=no_done");
            end else begin
                e = q3.pop_front();
                chk("table3", 32'(if3.tbl), 32'(e.tbl));
                chk("match3", 32'(if3.match), 32'(e.match));
                chk("err_count3", 32'(if3.err_count), 32'(e.err));
                chk("first_err3", 32'(if3.first_err), 32'(e.first));
                chk("done_cycle3", 32'(cyc), 32'(e.done_at));
            end
        end
    end

    // Each vector on the SETTLE=3 instance must be held exactly 4 cycles.
    int         run3 = 0;
    logic [3:0] prev3 = '0;
    bit         have3 = 1'b0;
    always @(negedge clk) begin
        if (!rst && if3.busy === 1'b1) begin
            if (have3 && if3.dut_in == prev3) begin
                run3++;
            end else begin
                if (have3) chk("settle3_hold", 32'(run3), 32'(4));
                run3  = 1;
                have3 = 1'b1;
                prev3 = if3.dut_in;
            end
        end else begin
            have3 = 1'b0;
        end
    end

    task automatic drain(input int sel, input int budget);
        int n;
        n = 0;
        while (n < budget && ((sel == 1) ? q1.size() : q3.size()) != 0) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (((sel == 1) ? q1.size() : q3.size()) != 0) begin
            failures++;
            $display("FAIL drain%0d actual=pending required=empty", sel);
            if (sel == 1) q1.delete();
            else q3.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic scan(input int sel, input logic [15:0] f, input logic [15:0] e, input bit scramble);
        int per;
        per = (sel == 1) ? 2 : 4;
        @(negedge clk);
        if (sel == 1) begin
            func1        = f;
            if1.expected = e;
            if1.start    = 1'b1;
            q1.push_back(model(f, e, cyc + 1 + 16 * per));
        end else begin
            if3.expected = e;
            if3.start    = 1'b1;
            q3.push_back(model(sop_mask, e, cyc + 1 + 16 * per));
        end
        @(negedge clk);
        if (sel == 1) begin
            if1.start = 1'b0;
            chk("busy_after_start1", 32'(if1.busy), 32'(1));
            chk("dut_in_after_start1", 32'(if1.dut_in), 32'(0));
        end else begin
            if3.start = 1'b0;
            chk("busy_after_start3", 32'(if3.busy), 32'(1));
            chk("dut_in_after_start3", 32'(if3.dut_in), 32'(0));
        end
        if (scramble) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            if (sel == 1) if1.expected = 16'($urandom);
            else if3.expected = 16'($urandom);
        end
        drain(sel, 40 * per);
    endtask

    initial begin
        logic [15:0] f;
        logic [15:0] e;
        logic [15:0] e2;
        int          c;
        int          n;

        rst          = 1'b1;
        if1.start    = 1'b0;
        if3.start    = 1'b0;
        if1.expected = '0;
        if3.expected = '0;
        sop_mask     = sop_truth();
        func1        = sop_mask;
        repeat (3) @(negedge clk);
        chk_reset1();
        rst = 1'b0;

        // Golden SoP, matching, single-bit mismatch, all-mismatch.
        scan(1, sop_mask, SOP_C_MASK, 1'b0);
        chk("idle_persist_table", 32'(if1.tbl), 32'(sop_mask));
        chk("idle_persist_match", 32'(if1.match), 32'(1));
        scan(1, sop_mask, 16'hD0C5, 1'b0);
        scan(1, 16'hFFFF, 16'h0000, 1'b0);

        // Asynchronous reset in the middle of a scan.
        @(negedge clk);
        func1        = sop_mask;
        if1.expected = SOP_C_MASK;
        if1.start    = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        n = 0;
        while (if1.dut_in != 4'd5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idx5", 32'(if1.dut_in), 32'(5));
        #2 rst = 1'b1;
        #1 chk_reset1();
        @(negedge clk);
        rst = 1'b0;
        scan(1, sop_mask, SOP_C_MASK, 1'b0);

        // start held high; expected changed mid-scan.
        @(negedge clk);
        c            = cyc;
        e2           = 16'($urandom);
        func1        = sop_mask;
        if1.expected = SOP_C_MASK;
        if1.start    = 1'b1;
        q1.push_back(model(sop_mask, SOP_C_MASK, c + 1 + 32));
        q1.push_back(model(sop_mask, e2, c + 35 + 32));
        repeat (10) @(negedge clk);
        if1.expected = e2;
        while (cyc < c + 35) @(negedge clk);
        if1.start = 1'b0;
        drain(1, 120);

        // Random functions and expected masks.
        for (int k = 0; k < 8; k++) begin
            f = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       e = f;
                1:       e = f ^ (16'h1 << $urandom_range(0, 15));
                2:       e = ~f;
                default: e = 16'($urandom);
            endcase
            scan(1, f, e, 1'b1);
        end

        // Longer settle time.
        scan(3, sop_mask, SOP_C_MASK, 1'b0);
        scan(3, sop_mask, 16'($urandom), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
